// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Basic ops finish in one cycle; MULT/MULTU/DIV/DIVU take WIDTH+1 cycles.
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       alu_control_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              div0_q, div0_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  wrk_q, wrk_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              zero_q, zero_d;
  logic              valid_q, valid_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   basic;
  logic               is_md, md_req, bas_req;
  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   ma, mb;
  logic [WIDTH:0]     mul_sum, trial;
  logic [WIDTH-1:0]   step_acc, step_wrk;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

  assign shamt   = a_i[SHAMT_W-1:0];
  assign is_md   = alu_control_i inside {4'd10, 4'd11, 4'd12, 4'd13};
  assign md_req  = valid_i & is_md;
  assign bas_req = valid_i & ~is_md;

  always_comb begin
    basic = '0;
    case (alu_control_i)
      4'd0:    basic = a_i & b_i;
      4'd1:    basic = a_i | b_i;
      4'd2:    basic = a_i + b_i;
      4'd3:    basic = b_i << shamt;
      4'd4:    basic = a_i & ~b_i;
      4'd5:    basic = a_i | ~b_i;
      4'd6:    basic = a_i - b_i;
      4'd7:    basic = {{(WIDTH-1){1'b0}}, a_i < b_i};
      4'd8:    basic = b_i >> shamt;
      4'd9:    basic = WIDTH'($signed(b_i) >>> shamt);
      4'd14:   basic = hi_q;
      4'd15:   basic = lo_q;
      default: basic = '0;
    endcase
  end

  // Signed ops run on magnitudes; signs are re-applied at completion.
  assign sgn   = (alu_control_i == 4'd10) | (alu_control_i == 4'd12);
  assign a_neg = sgn & a_i[WIDTH-1];
  assign b_neg = sgn & b_i[WIDTH-1];
  assign ma    = a_neg ? -a_i : a_i;
  assign mb    = b_neg ? -b_i : b_i;

  assign mul_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, m_q} : '0);
  assign trial   = {acc_q, wrk_q[WIDTH-1]} - {1'b0, m_q};

  always_comb begin
    step_acc = mul_sum[WIDTH:1];
    step_wrk = {mul_sum[0], wrk_q[WIDTH-1:1]};
    if (is_div_q) begin
      step_acc = trial[WIDTH] ? {acc_q[WIDTH-2:0], wrk_q[WIDTH-1]}
                              : trial[WIDTH-1:0];
      step_wrk = {wrk_q[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  assign prod   = {step_acc, step_wrk};
  assign prod_s = negq_q ? -prod : prod;
  assign quo    = negq_q ? -step_wrk : step_wrk;
  assign rem    = negr_q ? -step_acc : step_acc;

  always_comb begin
    fin_hi = prod_s[2*WIDTH-1:WIDTH];
    fin_lo = prod_s[WIDTH-1:0];
    if (is_div_q) begin
      fin_hi = div0_q ? a_q : rem;
      fin_lo = div0_q ? '1 : quo;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    a_d      = a_q;
    m_d      = m_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          md_req: begin
            is_div_d = alu_control_i[2];
            div0_d   = (b_i == '0);
            negq_d   = a_neg ^ b_neg;
            negr_d   = a_neg;
            a_d      = a_i;
            m_d      = alu_control_i[2] ? mb : ma;
            wrk_d    = alu_control_i[2] ? ma : mb;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
            state_d  = BUSY;
          end
          bas_req: begin
            res_d   = basic;
            zero_d  = (basic == '0);
            valid_d = 1'b1;
          end
          default: ;
        endcase
      end
      BUSY: begin
        acc_d = step_acc;
        wrk_d = step_wrk;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(2)) state_d = DONE;
      end
      DONE: begin
        hi_d    = fin_hi;
        lo_d    = fin_lo;
        res_d   = fin_lo;
        zero_d  = (fin_lo == '0);
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      a_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      a_q      <= a_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q != IDLE);
  assign valid_o  = valid_q;
  assign result_o = res_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: 32-bit instance with a HI/LO model,
// plus a small directed check of an 8-bit instance.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        ready, vld, zero, busy;
  logic [31:0] res;

  logic        v8_i;
  logic [7:0]  a8, b8;
  logic [3:0]  op8;
  logic        ready8, vld8, zero8, busy8;
  logic [7:0]  res8;

  always #5 clk = ~clk;

  alu_mdu dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready),
    .a_i(a), .b_i(b), .alu_control_i(op), .valid_o(vld),
    .result_o(res), .zero_o(zero), .busy_o(busy)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v8_i), .ready_o(ready8),
    .a_i(a8), .b_i(b8), .alu_control_i(op8), .valid_o(vld8),
    .result_o(res8), .zero_o(zero8), .busy_o(busy8)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] r;
    logic [63:0] p;
    longint      lp;
    int          sx, sy;
    sx = x;
    sy = y;
    r  = '0;
    case (o)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd3:  r = y << x[4:0];
      4'd4:  r = x & ~y;
      4'd5:  r = x | ~y;
      4'd6:  r = x - y;
      4'd7:  r = (x < y) ? 32'd1 : 32'd0;
      4'd8:  r = y >> x[4:0];
      4'd9:  r = $signed(y) >>> x[4:0];
      4'd10: begin
        lp = longint'(sx) * longint'(sy);
        p  = lp;
        m_hi = p[63:32];
        m_lo = p[31:0];
        r = m_lo;
      end
      4'd11: begin
        p = {32'b0, x} * {32'b0, y};
        m_hi = p[63:32];
        m_lo = p[31:0];
        r = m_lo;
      end
      4'd12: begin
        if (y == 0) begin
          m_lo = '1; m_hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = x; m_hi = '0;
        end else begin
          m_lo = sx / sy; m_hi = sx % sy;
        end
        r = m_lo;
      end
      4'd13: begin
        if (y == 0) begin
          m_lo = '1; m_hi = x;
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
        r = m_lo;
      end
      4'd14: r = m_hi;
      default: r = m_lo;
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : mon
    exp_t e;
    if (vld) begin
      if (sbq.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        check({e.tag, "_res"}, res, e.res);
        check({e.tag, "_zero"}, zero, e.res == 0);
        check({e.tag, "_lat"}, cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input string tag);
    exp_t e;
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check({tag, "_ready_timeout"}, 0, 1);
    op = o; a = x; b = y; valid_i = 1'b1;
    e.res = model(o, x, y);
    e.lat = (o inside {4'd10, 4'd11, 4'd12, 4'd13}) ? 32 : 0;
    e.tag = tag;
    @(posedge clk); #1;
    e.acc = cyc;
    valid_i = 1'b0;
    sbq.push_back(e);
  endtask

  initial begin
    int n;
    logic [3:0] ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; valid_i = 1'b0; a = '0; b = '0; op = '0;
    v8_i = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", res, 0);
    check("rst_zero", zero, 1);
    check("rst_valid", vld, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'd9, 32'd4, 32'h8000_0000, "sra");
    issue(4'd6, 32'd5, 32'd5, "sub0");
    issue(4'd2, 32'hFFFF_FFFF, 32'd1, "addwrap");
    issue(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, "and");
    issue(4'd1, 32'hF000_0000, 32'h0000_000F, "or");
    issue(4'd3, 32'hFFFF_FFE4, 32'h0000_0003, "sll");
    issue(4'd4, 32'hFFFF_00FF, 32'h0F0F_0F0F, "andn");
    issue(4'd5, 32'h0000_0001, 32'hFFFF_FFFE, "orn");
    issue(4'd7, 32'd3, 32'hFFFF_FFFF, "sltu1");
    issue(4'd7, 32'hFFFF_FFFF, 32'd3, "sltu0");
    issue(4'd8, 32'd31, 32'h8000_0000, "srl");

    issue(4'd10, 32'hFFFF_FFFD, 32'd5, "mult");
    issue(4'd14, 32'd0, 32'd0, "mfhi_mult");
    issue(4'd15, 32'd0, 32'd0, "mflo_mult");
    issue(4'd11, 32'hFFFF_FFFF, 32'd2, "multu");
    issue(4'd14, 32'd0, 32'd0, "mfhi_multu");
    issue(4'd13, 32'd100, 32'd7, "divu");
    issue(4'd14, 32'd0, 32'd0, "mfhi_divu");
    issue(4'd12, 32'hFFFF_FFF9, 32'd2, "div");
    issue(4'd14, 32'd0, 32'd0, "mfhi_div");
    issue(4'd13, 32'd5, 32'd0, "divu0");
    issue(4'd14, 32'd0, 32'd0, "mfhi_divu0");
    issue(4'd12, 32'hFFFF_FFF9, 32'd0, "div0neg");
    issue(4'd14, 32'd0, 32'd0, "mfhi_div0neg");
    issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    issue(4'd14, 32'd0, 32'd0, "mfhi_divovf");

    issue(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, "multu_hold");
    valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = 4'(i); a = $urandom; b = $urandom;
      check("hold_ready", ready, 0);
      check("hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    issue(4'd15, 32'd0, 32'd0, "mflo_after");
    issue(4'd14, 32'd0, 32'd0, "mfhi_after");

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue(ro, ra, rb, "rnd");
    end

    issue(4'd13, 32'd1000, 32'd3, "div_rst");
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res", res, 0);
    check("mid_rst_zero", zero, 1);
    check("mid_rst_valid", vld, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", ready, 1);
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'd14, 32'd0, 32'd0, "mfhi_post_rst");
    issue(4'd15, 32'd0, 32'd0, "mflo_post_rst");

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sbq.size(), 0);

    op8 = 4'd11; a8 = 8'hFF; b8 = 8'hFF; v8_i = 1'b1;
    @(posedge clk); #1;
    v8_i = 1'b0;
    n = 0;
    while (!vld8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_mul_lat", n, 8);
    check("w8_mul_lo", res8, 8'h01);
    op8 = 4'd14; v8_i = 1'b1;
    @(posedge clk); #1;
    v8_i = 1'b0;
    check("w8_mfhi_vld", vld8, 1);
    check("w8_mfhi", res8, 8'hFE);
    op8 = 4'd3; a8 = 8'h0B; b8 = 8'h01; v8_i = 1'b1;
    @(posedge clk); #1;
    v8_i = 1'b0;
    check("w8_sll_vld", vld8, 1);
    check("w8_sll", res8, 8'h08);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
